// File: rtl/dense_layer_engine_if.sv
// Stream and ROM-port bundle for the dense layer engine.
// master is the engine side; slave is the surrounding pipeline and ROMs.
interface dense_layer_engine_if #(
    parameter int unsigned DW  = 8,
    parameter int unsigned WAW = 8,
    parameter int unsigned BAW = 4
);
    logic           in_valid;
    logic [DW-1:0]  in_data;
    logic           in_ready;
    logic [WAW-1:0] w_addr;
    logic [DW-1:0]  w_data;
    logic [BAW-1:0] b_addr;
    logic [DW-1:0]  b_data;
    logic           out_valid;
    logic [DW-1:0]  out_data;
    logic           out_ready;

    modport master (
        input  in_valid, in_data, w_data, b_data, out_ready,
        output in_ready, w_addr, b_addr, out_valid, out_data
    );

    modport slave (
        output in_valid, in_data, w_data, b_data, out_ready,
        input  in_ready, w_addr, b_addr, out_valid, out_data
    );
endinterface

// File: rtl/dense_layer_engine.sv
// Fully-connected layer engine: buffers N_IN activations, computes N_OUT neurons one MAC per
// cycle against synchronous weight/bias ROMs, then streams the saturated results out.
module dense_layer_engine #(
    parameter int unsigned N_IN  = 16,
    parameter int unsigned N_OUT = 10,
    parameter int unsigned DW    = 8,
    parameter int unsigned FRAC  = 0,
    parameter int unsigned ACCW  = 2 * DW + $clog2(N_IN) + 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start_i,
    input  logic                 relu_en_i,
    dense_layer_engine_if.master bus,
    output logic                 busy_o,
    output logic                 done_o
);
    localparam int unsigned IW  = (N_IN > 1) ? $clog2(N_IN) : 1;
    localparam int unsigned OW  = (N_OUT > 1) ? $clog2(N_OUT) : 1;
    localparam int unsigned WAW = (N_IN * N_OUT > 1) ? $clog2(N_IN * N_OUT) : 1;
    localparam int unsigned RW  = ACCW + FRAC + 2;

    localparam logic signed [RW-1:0] SatMax = {{(RW - DW + 1){1'b0}}, {(DW - 1){1'b1}}};
    localparam logic signed [RW-1:0] SatMin = {{(RW - DW + 1){1'b1}}, {(DW - 1){1'b0}}};

    typedef enum logic [2:0] {StIdle, StLoad, StMac, StBias, StOut} state_e;

    state_e                 state_q, state_d;
    logic [IW-1:0]          in_idx_q, in_idx_d;
    logic [OW-1:0]          out_idx_q, out_idx_d;
    logic signed [ACCW-1:0] acc_q, acc_d;
    logic                   relu_q, relu_d;
    logic                   done_q, done_d;

    logic signed [DW-1:0]   in_buf_q [N_IN];
    logic signed [DW-1:0]   out_buf_q [N_OUT];

    logic                   last_in, last_out;
    logic [IW-1:0]          rd_idx;
    logic signed [2*DW-1:0] prod;
    logic signed [ACCW-1:0] acc_sum;
    logic signed [RW-1:0]   res, y;
    logic signed [DW-1:0]   y_sat;

    assign last_in  = (in_idx_q == IW'(N_IN - 1));
    assign last_out = (out_idx_q == OW'(N_OUT - 1));

    // w_data lags w_addr by a cycle, so MAC multiplies the previous index; BIAS takes the last.
    assign rd_idx = (state_q == StBias) ? in_idx_q : in_idx_q - IW'(1);

    always_comb begin
        prod    = in_buf_q[rd_idx] * $signed(bus.w_data);
        acc_sum = acc_q + ACCW'(prod);
        res     = RW'(acc_sum) + (RW'($signed(bus.b_data)) <<< FRAC);
        y       = res >>> FRAC;
        if (relu_q && y[RW-1]) begin
            y = '0;
        end
        if (y > SatMax) begin
            y_sat = SatMax[DW-1:0];
        end else if (y < SatMin) begin
            y_sat = SatMin[DW-1:0];
        end else begin
            y_sat = y[DW-1:0];
        end
    end

    always_comb begin
        state_d   = state_q;
        in_idx_d  = in_idx_q;
        out_idx_d = out_idx_q;
        acc_d     = acc_q;
        relu_d    = relu_q;
        done_d    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    state_d = StLoad;
                    relu_d  = relu_en_i;
                end
            end
            StLoad: begin
                if (bus.in_valid) begin
                    if (last_in) begin
                        in_idx_d = '0;
                        acc_d    = '0;
                        state_d  = StMac;
                    end else begin
                        in_idx_d = in_idx_q + IW'(1);
                    end
                end
            end
            StMac: begin
                if (in_idx_q != '0) begin
                    acc_d = acc_sum;
                end
                if (last_in) begin
                    state_d = StBias;
                end else begin
                    in_idx_d = in_idx_q + IW'(1);
                end
            end
            StBias: begin
                acc_d    = '0;
                in_idx_d = '0;
                if (last_out) begin
                    out_idx_d = '0;
                    state_d   = StOut;
                end else begin
                    out_idx_d = out_idx_q + OW'(1);
                    state_d   = StMac;
                end
            end
            StOut: begin
                if (bus.out_ready) begin
                    if (last_out) begin
                        out_idx_d = '0;
                        state_d   = StIdle;
                        done_d    = 1'b1;
                    end else begin
                        out_idx_d = out_idx_q + OW'(1);
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            in_idx_q  <= '0;
            out_idx_q <= '0;
            acc_q     <= '0;
            relu_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            in_idx_q  <= in_idx_d;
            out_idx_q <= out_idx_d;
            acc_q     <= acc_d;
            relu_q    <= relu_d;
            done_q    <= done_d;
        end
    end

    always_ff @(posedge clk) begin
        if (state_q == StLoad && bus.in_valid) begin
            in_buf_q[in_idx_q] <= bus.in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (state_q == StBias) begin
            out_buf_q[out_idx_q] <= y_sat;
        end
    end

    assign bus.in_ready  = (state_q == StLoad);
    assign bus.out_valid = (state_q == StOut);
    assign bus.out_data  = (state_q == StOut) ? out_buf_q[out_idx_q] : '0;
    assign bus.w_addr    = WAW'(out_idx_q) * WAW'(N_IN) + WAW'(in_idx_q);
    assign bus.b_addr    = out_idx_q;
    assign busy_o        = (state_q != StIdle);
    assign done_o        = done_q;
endmodule

// File: tb/tb_dense_layer_engine.sv
// Directed bench: a 4-in/3-out instance for the nominal scenarios and a 1-in/1-out FRAC=2
// instance for the edge configuration and back-to-back starts.
module tb_dense_layer_engine;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic start = 1'b0, relu_en = 1'b0, busy, done;
    logic start_e = 1'b0, relu_en_e = 1'b0, busy_e, done_e;

    dense_layer_engine_if #(.DW(8), .WAW(4), .BAW(2)) bus ();
    dense_layer_engine_if #(.DW(8), .WAW(1), .BAW(1)) bus_e ();

    dense_layer_engine #(.N_IN(4), .N_OUT(3), .DW(8), .FRAC(0)) dut (
        .clk(clk), .rst(rst), .start_i(start), .relu_en_i(relu_en),
        .bus(bus), .busy_o(busy), .done_o(done)
    );

    dense_layer_engine #(.N_IN(1), .N_OUT(1), .DW(8), .FRAC(2)) dut_e (
        .clk(clk), .rst(rst), .start_i(start_e), .relu_en_i(relu_en_e),
        .bus(bus_e), .busy_o(busy_e), .done_o(done_e)
    );

    logic signed [7:0] wrom [12];
    logic signed [7:0] brom [3];
    logic signed [7:0] wrom_e [2];
    logic signed [7:0] brom_e [2];
    logic signed [7:0] ins [4];

    always @(posedge clk) begin
        bus.w_data   <= wrom[bus.w_addr];
        bus.b_data   <= brom[bus.b_addr];
        bus_e.w_data <= wrom_e[bus_e.w_addr];
        bus_e.b_data <= brom_e[bus_e.b_addr];
    end

    int checks = 0;
    int failures = 0;
    int lat, nbeats, extra_valid, done_cnt, done_busy_bad;
    bit stream_ok;
    logic signed [7:0] got [3];

    always @(negedge clk) begin
        if (done === 1'b1) begin
            done_cnt++;
            if (busy !== 1'b0) done_busy_bad++;
        end
    end

    task automatic do_start(input logic relu);
        @(negedge clk);
        start = 1'b1;
        relu_en = relu;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Returns one negedge after the edge that takes the fourth beat.
    task automatic load_inputs(input bit gaps);
        int k = 0;
        int cyc = 0;
        bit hs;
        while (k < 4 && cyc < 50) begin
            if (gaps && (cyc % 2 == 1)) begin
                bus.in_valid = 1'b0;
                bus.in_data  = 8'sd99;
            end else begin
                bus.in_valid = 1'b1;
                bus.in_data  = ins[k];
            end
            hs = bus.in_valid && bus.in_ready;
            @(negedge clk);
            cyc++;
            if (hs) k++;
        end
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        checks++;
        if (k != 4) begin
            failures++;
            $display("FAIL load_beats got=%0d exp=4", k);
        end
    endtask

    task automatic wait_first_out(input bit mac_start, input bit relu_flip);
        lat = 0;
        while (bus.out_valid !== 1'b1 && lat < 100) begin
            start = (mac_start && lat == 3);
            if (relu_flip && lat == 0) relu_en = ~relu_en;
            @(negedge clk);
            lat++;
        end
        start = 1'b0;
    endtask

    task automatic collect_outputs(input int stall);
        int cyc = 0;
        int stall_left = stall;
        logic signed [7:0] held = '0;
        nbeats = 0;
        stream_ok = 1'b1;
        for (int i = 0; i < 3; i++) got[i] = 8'sd85;
        while (nbeats < 3 && cyc < 100) begin
            if (bus.out_valid === 1'b1) begin
                if (nbeats == 1 && stall_left > 0) begin
                    if (stall_left == stall) held = bus.out_data;
                    else if (bus.out_data !== held) stream_ok = 1'b0;
                    bus.out_ready = 1'b0;
                    stall_left--;
                end else begin
                    if (nbeats == 1 && stall > 0 && bus.out_data !== held) stream_ok = 1'b0;
                    bus.out_ready = 1'b1;
                    got[nbeats] = bus.out_data;
                    nbeats++;
                end
            end else begin
                bus.out_ready = 1'b0;
                stream_ok = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        bus.out_ready = 1'b0;
        extra_valid = 0;
        for (int i = 0; i < 4; i++) begin
            if (bus.out_valid !== 1'b0) extra_valid++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%0b exp=0", busy); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%0b exp=0", done); end
        checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready got=%0b exp=0", bus.in_ready); end
        checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%0b exp=0", bus.out_valid); end
        checks++; if (bus.out_data !== 8'h00) begin failures++; $display("FAIL reset_out_data got=%0h exp=0", bus.out_data); end
        checks++; if (bus.w_addr !== 4'h0 || bus.b_addr !== 2'h0) begin failures++; $display("FAIL reset_addr got=%0h/%0h exp=0/0", bus.w_addr, bus.b_addr); end
        checks++; if (busy_e !== 1'b0 || bus_e.out_valid !== 1'b0) begin failures++; $display("FAIL reset_edge got=%0b/%0b exp=0/0", busy_e, bus_e.out_valid); end
        rst = 1'b0;
    endtask

    task automatic test_idle_ignore();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            bus.in_valid = 1'b1;
            bus.in_data  = 8'sd55;
            checks++;
            if (bus.in_ready !== 1'b0 || busy !== 1'b0) begin
                failures++;
                $display("FAIL idle_in_valid cyc=%0d in_ready=%0b busy=%0b exp=0/0", i, bus.in_ready, busy);
            end
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL idle_stay got=%0b exp=0", busy); end
    endtask

    task automatic test_nominal();
        done_cnt = 0; done_busy_bad = 0;
        do_start(1'b0);
        load_inputs(1'b0);
        checks++; if (busy !== 1'b1 || bus.in_ready !== 1'b0) begin failures++; $display("FAIL nominal_mac_state busy=%0b in_ready=%0b exp=1/0", busy, bus.in_ready); end
        wait_first_out(1'b0, 1'b0);
        checks++; if (lat != 15) begin failures++; $display("FAIL nominal_latency got=%0d exp=15", lat); end
        collect_outputs(0);
        checks++; if (got[0] !== 8'sd10) begin failures++; $display("FAIL nominal_out0 got=%0d exp=10", got[0]); end
        checks++; if (got[1] !== -8'sd5) begin failures++; $display("FAIL nominal_out1 got=%0d exp=-5", got[1]); end
        checks++; if (got[2] !== 8'sd127) begin failures++; $display("FAIL nominal_out2 got=%0d exp=127", got[2]); end
        checks++; if (!stream_ok || extra_valid != 0) begin failures++; $display("FAIL nominal_stream ok=%0b extra=%0d exp=1/0", stream_ok, extra_valid); end
        checks++; if (done_cnt != 1) begin failures++; $display("FAIL nominal_done_pulses got=%0d exp=1", done_cnt); end
        checks++; if (done_busy_bad != 0) begin failures++; $display("FAIL nominal_busy_at_done got=%0d exp=0", done_busy_bad); end
    endtask

    task automatic test_relu();
        do_start(1'b1);
        load_inputs(1'b0);
        wait_first_out(1'b0, 1'b1);
        collect_outputs(0);
        checks++; if (got[0] !== 8'sd10) begin failures++; $display("FAIL relu_out0 got=%0d exp=10", got[0]); end
        checks++; if (got[1] !== 8'sd0) begin failures++; $display("FAIL relu_out1 got=%0d exp=0", got[1]); end
        checks++; if (got[2] !== 8'sd127) begin failures++; $display("FAIL relu_out2 got=%0d exp=127", got[2]); end
    endtask

    task automatic test_in_backpressure();
        do_start(1'b0);
        load_inputs(1'b1);
        wait_first_out(1'b0, 1'b0);
        checks++; if (lat != 15) begin failures++; $display("FAIL in_bp_latency got=%0d exp=15", lat); end
        collect_outputs(0);
        checks++; if (got[0] !== 8'sd10 || got[1] !== -8'sd5 || got[2] !== 8'sd127) begin
            failures++; $display("FAIL in_bp_outputs got=%0d,%0d,%0d exp=10,-5,127", got[0], got[1], got[2]);
        end
    endtask

    task automatic test_out_backpressure();
        done_cnt = 0;
        do_start(1'b0);
        load_inputs(1'b0);
        wait_first_out(1'b0, 1'b0);
        collect_outputs(3);
        checks++; if (!stream_ok) begin failures++; $display("FAIL out_bp_stable got=%0b exp=1", stream_ok); end
        checks++; if (got[0] !== 8'sd10 || got[1] !== -8'sd5 || got[2] !== 8'sd127) begin
            failures++; $display("FAIL out_bp_outputs got=%0d,%0d,%0d exp=10,-5,127", got[0], got[1], got[2]);
        end
        checks++; if (extra_valid != 0 || done_cnt != 1) begin failures++; $display("FAIL out_bp_tail extra=%0d done=%0d exp=0/1", extra_valid, done_cnt); end
    endtask

    task automatic test_start_during_mac();
        done_cnt = 0;
        do_start(1'b0);
        load_inputs(1'b0);
        wait_first_out(1'b1, 1'b0);
        checks++; if (lat != 15) begin failures++; $display("FAIL mac_start_latency got=%0d exp=15", lat); end
        collect_outputs(0);
        checks++; if (got[0] !== 8'sd10 || got[1] !== -8'sd5 || got[2] !== 8'sd127) begin
            failures++; $display("FAIL mac_start_outputs got=%0d,%0d,%0d exp=10,-5,127", got[0], got[1], got[2]);
        end
        checks++; if (done_cnt != 1) begin failures++; $display("FAIL mac_start_done got=%0d exp=1", done_cnt); end
    endtask

    task automatic test_reset_during_mac();
        int seen_valid = 0;
        done_cnt = 0;
        do_start(1'b0);
        load_inputs(1'b0);
        repeat (6) @(negedge clk);
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL rst_mac_busy_before got=%0b exp=1", busy); end
        rst = 1'b1;
        #1;
        checks++; if (busy !== 1'b0 || bus.in_ready !== 1'b0) begin failures++; $display("FAIL rst_mac_async busy=%0b in_ready=%0b exp=0/0", busy, bus.in_ready); end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (bus.out_valid !== 1'b0 || busy !== 1'b0) seen_valid++;
            @(negedge clk);
        end
        checks++; if (seen_valid != 0 || done_cnt != 0) begin failures++; $display("FAIL rst_mac_quiet active=%0d done=%0d exp=0/0", seen_valid, done_cnt); end
        do_start(1'b0);
        load_inputs(1'b0);
        wait_first_out(1'b0, 1'b0);
        collect_outputs(0);
        checks++; if (got[0] !== 8'sd10 || got[1] !== -8'sd5 || got[2] !== 8'sd127) begin
            failures++; $display("FAIL rst_mac_rerun got=%0d,%0d,%0d exp=10,-5,127", got[0], got[1], got[2]);
        end
    endtask

    task automatic test_back_to_back();
        int elat;
        @(negedge clk);
        start_e = 1'b1;
        relu_en_e = 1'b0;
        @(negedge clk);
        start_e = 1'b0;
        bus_e.in_valid = 1'b1;
        bus_e.in_data = 8'sd8;
        checks++; if (bus_e.in_ready !== 1'b1) begin failures++; $display("FAIL edge_load got=%0b exp=1", bus_e.in_ready); end
        @(negedge clk);
        bus_e.in_valid = 1'b0;
        elat = 0;
        while (bus_e.out_valid !== 1'b1 && elat < 20) begin @(negedge clk); elat++; end
        checks++; if (elat != 2) begin failures++; $display("FAIL edge_latency got=%0d exp=2", elat); end
        checks++; if (bus_e.out_data !== 8'sd7) begin failures++; $display("FAIL edge_out_first got=%0d exp=7", $signed(bus_e.out_data)); end
        bus_e.out_ready = 1'b1;
        @(negedge clk);
        bus_e.out_ready = 1'b0;
        checks++; if (done_e !== 1'b1 || busy_e !== 1'b0) begin failures++; $display("FAIL edge_done done=%0b busy=%0b exp=1/0", done_e, busy_e); end
        start_e = 1'b1;
        @(negedge clk);
        start_e = 1'b0;
        checks++; if (busy_e !== 1'b1 || bus_e.in_ready !== 1'b1 || done_e !== 1'b0) begin
            failures++; $display("FAIL edge_b2b_accept busy=%0b in_ready=%0b done=%0b exp=1/1/0", busy_e, bus_e.in_ready, done_e);
        end
        bus_e.in_valid = 1'b1;
        bus_e.in_data = -8'sd4;
        @(negedge clk);
        bus_e.in_valid = 1'b0;
        elat = 0;
        while (bus_e.out_valid !== 1'b1 && elat < 20) begin @(negedge clk); elat++; end
        checks++; if (bus_e.out_data !== -8'sd2) begin failures++; $display("FAIL edge_out_second got=%0d exp=-2", $signed(bus_e.out_data)); end
        bus_e.out_ready = 1'b1;
        @(negedge clk);
        bus_e.out_ready = 1'b0;
        checks++; if (done_e !== 1'b1) begin failures++; $display("FAIL edge_done2 got=%0b exp=1", done_e); end
        @(negedge clk);
        checks++; if (done_e !== 1'b0 || bus_e.out_valid !== 1'b0) begin failures++; $display("FAIL edge_done_pulse done=%0b valid=%0b exp=0/0", done_e, bus_e.out_valid); end
    endtask

    initial begin
        ins = '{8'sd1, 8'sd2, 8'sd3, 8'sd4};
        for (int i = 0; i < 4; i++) begin
            wrom[i]     = 8'sd1;
            wrom[4 + i] = -8'sd1;
            wrom[8 + i] = 8'sd127;
        end
        brom   = '{8'sd0, 8'sd5, 8'sd0};
        wrom_e = '{8'sd3, 8'sd0};
        brom_e = '{8'sd1, 8'sd0};
        bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b0;
        bus_e.in_valid = 1'b0; bus_e.in_data = '0; bus_e.out_ready = 1'b0;

        test_reset();
        test_idle_ignore();
        test_nominal();
        test_relu();
        test_in_backpressure();
        test_out_backpressure();
        test_start_during_mac();
        test_reset_during_mac();
        test_back_to_back();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
